ps2_cmd_ctrl: RTL and testbench
===============================

// Module: ps2_cmd_ctrl
// PURPOSE
//  Host-to-keyboard command sequencer sharing the PS/2 bus with the ps2 receiver.
//  - Takes one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the system side.
//  - Gates the receiver off and drives the open-drain clock/data lines to send the frame.
//  - Hands the bus back to the receiver and waits for the device response byte.
//  - Retries on 0xFE (resend). Reports done or a coded error.
// PARAMETERS
//  INHIBIT_CYCLES  5000     clk cycles ps2clk is held low before the request (100 us at 50 MHz)
//  TIMEOUT_CYCLES  1000000  max clk cycles per attempt, measured from SEND entry to response byte
//  MAX_RETRY       2        resends allowed after 0xFE before giving up
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous reset, active-high
//  cmd_valid      in   1  command byte offered
//  cmd_byte       in   8  command byte
//  cmd_ready      out  1  high in IDLE only; transfer on cmd_valid & cmd_ready
//  ps2clk         in   1  raw PS/2 clock line (asynchronous)
//  ps2data        in   1  raw PS/2 data line (asynchronous)
//  ps2clk_oe      out  1  1 = pull clock line low, 0 = release
//  ps2data_oe     out  1  1 = pull data line low, 0 = release
//  rx_en          out  1  receiver enable; 0 while host owns the bus
//  rx_valid       in   1  1-cycle strobe from receiver: rx_byte is a good-parity byte
//  rx_byte        in   8  received byte
//  busy           out  1  high in every state except IDLE
//  done           out  1  1-cycle pulse: command acknowledged (0xFA)
//  err            out  1  1-cycle pulse: command failed
//  err_code       out  2  valid with err: 01 timeout, 10 no line ack, 11 retries exhausted; held until next err
// BEHAVIOUR
//  Reset values
//  - State IDLE, cmd_ready=1, ps2clk_oe=0, ps2data_oe=0, rx_en=1.
//  - busy=0, done=0, err=0, err_code=00. Retry, edge and timeout counters = 0.
//  - Reset mid-transfer releases both lines on the next cycle.
//  Edge detection
//  - ps2clk and ps2data each pass through a 2-flop synchronizer.
//  - fall = previous synced clock & ~current synced clock.
//  States
//  - IDLE: accept a command and latch cmd_byte; retry=0; go INHIBIT.
//  - INHIBIT: ps2clk_oe=1, ps2data_oe=0, rx_en=0, for INHIBIT_CYCLES cycles; then REQ.
//  - REQ: exactly 1 cycle, ps2clk_oe=1, ps2data_oe=1 (start bit); then SEND.
//  - SEND: ps2clk_oe=0, ps2data_oe stays 1. Edge count n=0 and timeout=0 on entry. On each fall, n++:
//    - n=1..8: drive data bit n-1, LSB first.
//    - n=9: drive odd parity, ~^byte.
//    - n=10: release data (stop bit).
//    - n=11: sample synced data. 0 -> WAIT_RESP; 1 -> err_code=10, go FAIL.
//    - Driving a bit: 0 -> oe=1, 1 -> oe=0.
//  - WAIT_RESP: both oe=0, rx_en=1. On rx_valid:
//    - rx_byte 0xFA -> DONE.
//    - rx_byte 0xFE -> if retry<MAX_RETRY then retry++ and go INHIBIT; else err_code=11, go FAIL.
//    - any other byte is ignored.
//  - Timeout: in SEND or WAIT_RESP, if timeout reaches TIMEOUT_CYCLES: err_code=01, go FAIL.
//    Counter is cleared on every SEND entry, including retries.
//  - DONE: done=1 for one cycle -> IDLE.
//  - FAIL: err=1 for one cycle, both oe=0, rx_en=1 -> IDLE.
//  Boundaries and simultaneous events
//  - Timeout and a qualifying event (fall or rx_valid) in the same cycle: the event wins.
//  - cmd_valid while busy is ignored (cmd_ready=0); no queuing.
//  - Falls seen in INHIBIT or REQ are ignored.
//  - Latency: cmd accept -> first line activity is 1 cycle; INHIBIT is exact (+/-0 cycles).
// TESTING
//  1. Send 0xED. Device model clocks 11 falls; bits seen are 1,0,1,1,0,1,1,1, parity 1, stop released.
//     Line ack 0, then rx 0xFA -> one done pulse; cmd_ready=1 next cycle.
//  2. Send 0xF4. Respond 0xFE, then 0xFA on the second attempt.
//     -> two INHIBIT periods of exactly 5000 cycles; done, no err.
//  3. MAX_RETRY=2, send 0xFF, respond 0xFE three times -> three frames, then err with err_code=11.
//  4. Device never clocks after REQ -> err, err_code=01, TIMEOUT_CYCLES after SEND entry; both oe=0.
//  5. Data high at the 11th fall -> err, err_code=10; rx_en=1 again.
//  6. rst pulse during SEND, n=5 -> next cycle: oe=0/0, rx_en=1, cmd_ready=1, busy=0.
//     A new command then completes normally.

Source files
------------

// File: rtl/ps2_cmd_ctrl_if.sv
// Bundle of the command, PS/2 line and receiver-handshake signals around ps2_cmd_ctrl.
// The master side is the system/device environment; the slave side is the controller.
interface ps2_cmd_ctrl_if;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       cmd_ready;
    logic       ps2clk;
    logic       ps2data;
    logic       ps2clk_oe;
    logic       ps2data_oe;
    logic       rx_en;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output cmd_valid, cmd_byte, ps2clk, ps2data, rx_valid, rx_byte,
        input  cmd_ready, ps2clk_oe, ps2data_oe, rx_en, busy, done, err, err_code
    );

    modport slave (
        input  cmd_valid, cmd_byte, ps2clk, ps2data, rx_valid, rx_byte,
        output cmd_ready, ps2clk_oe, ps2data_oe, rx_en, busy, done, err, err_code
    );
endinterface

// File: rtl/ps2_cmd_ctrl.sv
// Host-to-device PS/2 command sequencer: inhibits the bus, clocks out one command frame,
// then waits for the device response with resend retries and a per-attempt timeout.
module ps2_cmd_ctrl #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    ps2_cmd_ctrl_if.slave bus
);
    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1) + 1;

    typedef enum logic [2:0] {
        StIdle, StInhibit, StReq, StSend, StWaitResp, StDone, StFail
    } state_e;

    state_e           r_state;
    logic [1:0]       r_clk_sync;
    logic [1:0]       r_dat_sync;
    logic             r_clk_prev;
    logic [7:0]       r_byte;
    logic [INH_W-1:0] r_inh;
    logic [TMO_W-1:0] r_tmo;
    logic [RTY_W-1:0] r_retry;
    logic [3:0]       r_n;
    logic             r_cmd_ready;
    logic             r_clk_oe;
    logic             r_dat_oe;
    logic             r_rx_en;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [1:0]       r_err_code;

    logic w_fall;
    logic w_tmo_hit;
    logic w_parity;

    assign w_fall    = r_clk_prev & ~r_clk_sync[1];
    assign w_tmo_hit = (r_tmo >= TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_parity  = ~^r_byte;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_clk_sync  <= 2'b11;
            r_dat_sync  <= 2'b11;
            r_clk_prev  <= 1'b1;
            r_byte      <= '0;
            r_inh       <= '0;
            r_tmo       <= '0;
            r_retry     <= '0;
            r_n         <= '0;
            r_cmd_ready <= 1'b1;
            r_clk_oe    <= 1'b0;
            r_dat_oe    <= 1'b0;
            r_rx_en     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_clk_sync <= {r_clk_sync[0], bus.ps2clk};
            r_dat_sync <= {r_dat_sync[0], bus.ps2data};
            r_clk_prev <= r_clk_sync[1];
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        r_byte      <= bus.cmd_byte;
                        r_retry     <= '0;
                        r_inh       <= '0;
                        r_clk_oe    <= 1'b1;
                        r_dat_oe    <= 1'b0;
                        r_rx_en     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= StInhibit;
                    end
                end
                StInhibit: begin
                    if (r_inh == INH_W'(INHIBIT_CYCLES - 1)) begin
                        r_dat_oe <= 1'b1;
                        r_state  <= StReq;
                    end else begin
                        r_inh <= r_inh + 1'b1;
                    end
                end
                StReq: begin
                    r_clk_oe <= 1'b0;
                    r_n      <= '0;
                    r_tmo    <= '0;
                    r_state  <= StSend;
                end
                StSend: begin
                    // A device clock edge takes priority over an expiring timeout.
                    if (w_fall) begin
                        r_n   <= r_n + 1'b1;
                        r_tmo <= r_tmo + 1'b1;
                        if (r_n < 4'd8) begin
                            r_dat_oe <= ~r_byte[r_n[2:0]];
                        end else if (r_n == 4'd8) begin
                            r_dat_oe <= ~w_parity;
                        end else if (r_n == 4'd9) begin
                            r_dat_oe <= 1'b0;
                        end else begin
                            r_dat_oe <= 1'b0;
                            r_rx_en  <= 1'b1;
                            if (!r_dat_sync[1]) begin
                                r_state <= StWaitResp;
                            end else begin
                                r_err      <= 1'b1;
                                r_err_code <= 2'b10;
                                r_state    <= StFail;
                            end
                        end
                    end else if (w_tmo_hit) begin
                        r_dat_oe   <= 1'b0;
                        r_rx_en    <= 1'b1;
                        r_err      <= 1'b1;
                        r_err_code <= 2'b01;
                        r_state    <= StFail;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                StWaitResp: begin
                    if (bus.rx_valid) begin
                        r_tmo <= r_tmo + 1'b1;
                        if (bus.rx_byte == 8'hFA) begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else if (bus.rx_byte == 8'hFE) begin
                            if (r_retry < RTY_W'(MAX_RETRY)) begin
                                r_retry  <= r_retry + 1'b1;
                                r_inh    <= '0;
                                r_clk_oe <= 1'b1;
                                r_rx_en  <= 1'b0;
                                r_state  <= StInhibit;
                            end else begin
                                r_err      <= 1'b1;
                                r_err_code <= 2'b11;
                                r_state    <= StFail;
                            end
                        end
                    end else if (w_tmo_hit) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'b01;
                        r_state    <= StFail;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                StDone, StFail: begin
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= StIdle;
                end
                default: begin
                    r_clk_oe    <= 1'b0;
                    r_dat_oe    <= 1'b0;
                    r_rx_en     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.ps2clk_oe  = r_clk_oe;
    assign bus.ps2data_oe = r_dat_oe;
    assign bus.rx_en      = r_rx_en;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.err_code   = r_err_code;
endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Directed bench for ps2_cmd_ctrl: a table of command scenarios driven through a small
// device model, plus hand-written timeout, busy-command and mid-frame reset sequences.
module tb_ps2_cmd_ctrl;
    localparam int INH = 20;
    localparam int TMO = 300;
    localparam int RTY = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_cmd_ctrl_if bus ();

    ps2_cmd_ctrl #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .MAX_RETRY      (RTY)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] cmd;
        int         n_fe;
        bit         ack_high;
        bit         exp_par;
        bit         exp_done;
        bit         exp_err;
        logic [1:0] exp_code;
        int         exp_frames;
    } vec_t;

    vec_t vecs [6];
    int   n_vec = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;

    always @(negedge clk) begin
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.err)  err_cnt  <= err_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c);
        @(negedge clk);
        chk("cmd_ready_idle", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_byte  = c;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("accept_latency", {bus.ps2clk_oe, bus.ps2data_oe, bus.rx_en}, 3'b100);
    endtask

    task automatic respond(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    // Device side of one frame: counts the inhibit, checks REQ, then clocks nfalls edges.
    task automatic frame(input bit ack_high, input int nfalls, output logic [7:0] b,
                         output logic par, output logic stp, output int inh);
        int w;
        w = 0; b = '0; par = 1'b0; stp = 1'b0; inh = 0;
        while (!bus.ps2clk_oe && w < 200) begin
            @(negedge clk);
            w++;
        end
        while (bus.ps2clk_oe && !bus.ps2data_oe && inh < 4 * INH) begin
            inh++;
            @(negedge clk);
        end
        chk("req_cycle", {bus.ps2clk_oe, bus.ps2data_oe}, 2'b11);
        @(negedge clk);
        chk("send_entry", {bus.ps2clk_oe, bus.ps2data_oe}, 2'b01);
        for (int k = 1; k <= nfalls; k++) begin
            bus.ps2data = (k == 11) ? ack_high : 1'b1;
            repeat (4) @(negedge clk);
            bus.ps2clk = 1'b0;
            repeat (4) @(negedge clk);
            bus.ps2clk = 1'b1;
            if (k <= 8)       b[k-1] = ~bus.ps2data_oe;
            else if (k == 9)  par    = ~bus.ps2data_oe;
            else if (k == 10) stp    = ~bus.ps2data_oe;
        end
        bus.ps2data = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] b;
        logic       par, stp;
        int         inh, frames, fe_sent, d0, e0;
        frames = 0; fe_sent = 0;
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(v.cmd);
        for (int f = 0; f < 8; f++) begin
            frame(v.ack_high, 11, b, par, stp, inh);
            frames++;
            chk("frame_byte", 32'(b), 32'(v.cmd));
            chk("frame_parity", 32'(par), 32'(v.exp_par));
            chk("frame_stop", 32'(stp), 1);
            chk("inhibit_len", 32'(inh), INH);
            if (v.ack_high) break;
            chk("rx_en_wait", 32'(bus.rx_en), 1);
            respond(8'h55);
            if (fe_sent < v.n_fe) begin
                respond(8'hFE);
                fe_sent++;
                if (fe_sent > RTY) break;
            end else begin
                respond(8'hFA);
                chk("done_pulse", 32'(bus.done), 1);
                @(negedge clk);
                chk("ready_after_done", {bus.cmd_ready, bus.done, bus.busy}, 3'b100);
                break;
            end
        end
        repeat (4) @(negedge clk);
        chk("done_count", 32'(done_cnt - d0), 32'(v.exp_done));
        chk("err_count", 32'(err_cnt - e0), 32'(v.exp_err));
        if (v.exp_err) chk("err_code", 32'(bus.err_code), 32'(v.exp_code));
        chk("frame_count", 32'(frames), 32'(v.exp_frames));
        chk("idle_lines", {bus.cmd_ready, bus.ps2clk_oe, bus.ps2data_oe, bus.rx_en, bus.busy},
            5'b10010);
    endtask

    initial begin : main
        logic [7:0] b;
        logic       par, stp;
        int         inh, t;

        vecs[0] = '{8'hED, 0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1};
        vecs[1] = '{8'hF4, 1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2};
        vecs[2] = '{8'hFF, 3, 1'b0, 1'b1, 1'b0, 1'b1, 2'b11, 3};
        vecs[3] = '{8'h01, 0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1};
        vecs[4] = '{8'h80, 2, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3};
        vecs[5] = '{8'h00, 0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1};

        bus.cmd_valid = 1'b0; bus.cmd_byte = '0;
        bus.ps2clk = 1'b1; bus.ps2data = 1'b1;
        bus.rx_valid = 1'b0; bus.rx_byte = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_state", {bus.cmd_ready, bus.ps2clk_oe, bus.ps2data_oe, bus.rx_en, bus.busy,
                            bus.done, bus.err, bus.err_code}, 9'b1_0_0_1_0_0_0_00);

        // Device never clocks: err must land exactly TMO cycles after SEND entry.
        send_cmd(8'hED);
        t = 0;
        while (!(!bus.ps2clk_oe && bus.ps2data_oe) && t < 4 * INH) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (!bus.err && t < 2 * TMO) begin
            @(negedge clk);
            t++;
        end
        chk("timeout_cycles", 32'(t), TMO);
        chk("timeout_code", 32'(bus.err_code), 32'(2'b01));
        chk("timeout_lines", {bus.ps2clk_oe, bus.ps2data_oe, bus.rx_en}, 3'b001);
        repeat (3) @(negedge clk);

        // A second command offered while busy must not replace the latched one.
        send_cmd(8'hA5);
        bus.cmd_valid = 1'b1;
        bus.cmd_byte  = 8'h3C;
        @(negedge clk);
        chk("busy_not_ready", {bus.cmd_ready, bus.busy}, 2'b01);
        frame(1'b0, 11, b, par, stp, inh);
        bus.cmd_valid = 1'b0;
        chk("busy_cmd_byte", 32'(b), 32'h0A5);
        chk("busy_cmd_parity", 32'(par), 1);
        respond(8'hFA);
        repeat (3) @(negedge clk);

        // Reset after the fifth fall releases the bus on the next cycle.
        send_cmd(8'hED);
        frame(1'b0, 5, b, par, stp, inh);
        chk("partial_bits", 32'(b[4:0]), 32'h0D);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_send", {bus.ps2clk_oe, bus.ps2data_oe, bus.rx_en, bus.cmd_ready,
                               bus.busy}, 5'b00110);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
